if_fetch_stage: RTL and testbench

//   Stage 1 of the 6-stage pipeline: owns the PC, drives the instruction-memory

---
 rtl/if_fetch_stage_if.sv | 32 +++
 rtl/if_fetch_stage.sv | 115 +++++++++++
 tb/tb_if_fetch_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, hazard/redirect controls, IF/ID register and perf counters.
// master = fetch stage, slave = memory + downstream pipeline.
interface if_fetch_stage_if #(
    parameter int CNT_W = 32
);
    logic [15:0]      im_addr;
    logic [15:0]      im_data;
    logic             stall;
    logic             flush;
    logic             redirect;
    logic [15:0]      redirect_pc;
    logic [15:0]      pc;
    logic             ifid_valid;
    logic [15:0]      ifid_instr;
    logic [15:0]      ifid_pc;
    logic [15:0]      ifid_pc_inc;
    logic [CNT_W-1:0] perf_fetch;
    logic [CNT_W-1:0] perf_stall;
    logic [CNT_W-1:0] perf_bubble;

    modport master (
        output im_addr, pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_inc,
               perf_fetch, perf_stall, perf_bubble,
        input  im_data, stall, flush, redirect, redirect_pc
    );

    modport slave (
        input  im_addr, pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_inc,
               perf_fetch, perf_stall, perf_bubble,
        output im_data, stall, flush, redirect, redirect_pc
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Pipeline stage 1: PC, instruction-memory address and IF/ID register; priority redirect > flush > stall.
// Optional saturating perf counters enabled by defining FETCH_PERF_EN.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter int          CNT_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_stage_if.master fe
);
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ifid_pc_q, ifid_pc_d;
    logic [15:0] ifid_pc_inc_q, ifid_pc_inc_d;

    logic        do_fetch;
    logic        do_stall;
    logic        do_bubble;

    assign do_bubble = fe.redirect | fe.flush;
    assign do_stall  = fe.stall & ~do_bubble;
    assign do_fetch  = ~fe.stall & ~do_bubble;

    always_comb begin
        pc_d          = pc_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pc_inc_d = ifid_pc_inc_q;
        if (fe.redirect) begin
            pc_d    = fe.redirect_pc;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (fe.flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (!fe.stall) begin
            // PC wraps modulo 2^16 by construction of the 16-bit adder
            pc_d          = pc_q + 16'd1;
            valid_d       = 1'b1;
            instr_d       = fe.im_data;
            ifid_pc_d     = pc_q;
            ifid_pc_inc_d = pc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            valid_q       <= 1'b0;
            instr_q       <= NOP_INSTR;
            ifid_pc_q     <= 16'h0000;
            ifid_pc_inc_q <= 16'h0000;
        end else begin
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pc_inc_q <= ifid_pc_inc_d;
        end
    end

    assign fe.im_addr     = pc_q;
    assign fe.pc          = pc_q;
    assign fe.ifid_valid  = valid_q;
    assign fe.ifid_instr  = instr_q;
    assign fe.ifid_pc     = ifid_pc_q;
    assign fe.ifid_pc_inc = ifid_pc_inc_q;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counters stick at all-ones rather than wrapping
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (do_fetch && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
        if (do_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (do_bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fe.perf_fetch  = fetch_cnt_q;
    assign fe.perf_stall  = stall_cnt_q;
    assign fe.perf_bubble = bubble_cnt_q;
`else
    logic unused_perf;
    assign unused_perf    = do_fetch ^ do_stall;
    assign fe.perf_fetch  = {CNT_W{1'b0}};
    assign fe.perf_stall  = {CNT_W{1'b0}};
    assign fe.perf_bubble = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, stall, redirect, flush, wrap and perf counters.
// Perf expectations follow FETCH_PERF_EN the same way the design does.
module tb_if_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_fetch = 0;
    int   m_stall = 0;
    int   m_bubble = 0;

    if_fetch_stage_if #(.CNT_W(32)) fe ();

    if_fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(16'h0000),
        .CNT_W    (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fe (fe)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] imem(input logic [15:0] a);
        case (a)
            16'h0000: imem = 16'h3201;
            16'h0001: imem = 16'h0281;
            16'h0002: imem = 16'h07C2;
            default:  imem = a ^ 16'hA5A5;
        endcase
    endfunction

    always_comb fe.im_data = imem(fe.im_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with a small reference tally of what the perf counters should see.
    task automatic step();
        if (rst) begin
            m_fetch = 0; m_stall = 0; m_bubble = 0;
        end else if (fe.redirect || fe.flush) m_bubble++;
        else if (fe.stall) m_stall++;
        else m_fetch++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag);
`ifdef FETCH_PERF_EN
        chk({tag, "_fetch"},  fe.perf_fetch,  32'(m_fetch));
        chk({tag, "_stall"},  fe.perf_stall,  32'(m_stall));
        chk({tag, "_bubble"}, fe.perf_bubble, 32'(m_bubble));
`else
        chk({tag, "_fetch"},  fe.perf_fetch,  32'h0);
        chk({tag, "_stall"},  fe.perf_stall,  32'h0);
        chk({tag, "_bubble"}, fe.perf_bubble, 32'h0);
`endif
    endtask

    initial begin
        rst = 1'b1; fe.stall = 1'b0; fe.flush = 1'b0; fe.redirect = 1'b0; fe.redirect_pc = 16'h0;
        #1;
        step(); step();
        chk("rst_pc",     fe.pc, 32'h0);
        chk("rst_valid",  fe.ifid_valid, 32'h0);
        chk("rst_instr",  fe.ifid_instr, 32'h0);
        chk("rst_ifidpc", fe.ifid_pc, 32'h0);
        chk("rst_inc",    fe.ifid_pc_inc, 32'h0);
        chk_perf("rst_perf");
        rst = 1'b0;
        chk("imaddr0", fe.im_addr, 32'h0);

        step();
        chk("f0_pc", fe.pc, 32'h1);
        chk("f0_valid", fe.ifid_valid, 32'h1);
        chk("f0_instr", fe.ifid_instr, 32'h3201);
        chk("f0_ifidpc", fe.ifid_pc, 32'h0);
        chk("f0_inc", fe.ifid_pc_inc, 32'h1);

        fe.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", fe.pc, 32'h1);
            chk("stall_instr", fe.ifid_instr, 32'h3201);
            chk("stall_ifidpc", fe.ifid_pc, 32'h0);
        end
        fe.stall = 1'b0;
        step();
        chk("f1_instr", fe.ifid_instr, 32'h0281);
        chk("f1_ifidpc", fe.ifid_pc, 32'h1);
        chk("f1_pc", fe.pc, 32'h2);
        step();
        chk("f2_instr", fe.ifid_instr, 32'h07C2);
        chk("f2_ifidpc", fe.ifid_pc, 32'h2);
        chk("f2_inc", fe.ifid_pc_inc, 32'h3);
        chk("f2_pc", fe.pc, 32'h3);
        step(); step();
        chk("f4_pc", fe.pc, 32'h5);
        chk("f4_instr", fe.ifid_instr, 32'hA5A1);

        fe.redirect = 1'b1; fe.redirect_pc = 16'h0040; fe.stall = 1'b1;
        step();
        chk("rd_pc", fe.pc, 32'h0040);
        chk("rd_valid", fe.ifid_valid, 32'h0);
        chk("rd_instr", fe.ifid_instr, 32'h0);
        fe.redirect = 1'b0; fe.stall = 1'b0;
        step();
        chk("rd_f_ifidpc", fe.ifid_pc, 32'h0040);
        chk("rd_f_instr", fe.ifid_instr, 32'hA5E5);
        chk("rd_f_valid", fe.ifid_valid, 32'h1);
        chk("rd_f_pc", fe.pc, 32'h0041);

        fe.redirect = 1'b1; fe.redirect_pc = 16'h0006;
        step();
        fe.redirect = 1'b0;
        step();
        chk("to7_pc", fe.pc, 32'h7);
        fe.flush = 1'b1;
        step();
        chk("fl_valid", fe.ifid_valid, 32'h0);
        chk("fl_instr", fe.ifid_instr, 32'h0);
        chk("fl_pc", fe.pc, 32'h7);
        chk("fl_ifidpc_hold", fe.ifid_pc, 32'h6);
        fe.flush = 1'b0;
        step();
        chk("fl_f_ifidpc", fe.ifid_pc, 32'h7);
        chk("fl_f_instr", fe.ifid_instr, 32'hA5A2);
        chk("fl_f_pc", fe.pc, 32'h8);

        fe.flush = 1'b1; fe.stall = 1'b1;
        step();
        chk("flst_valid", fe.ifid_valid, 32'h0);
        chk("flst_pc", fe.pc, 32'h8);
        fe.flush = 1'b0; fe.stall = 1'b0;

        fe.redirect = 1'b1; fe.redirect_pc = 16'h0008;
        step();
        chk("rdself_pc", fe.pc, 32'h8);
        chk("rdself_valid", fe.ifid_valid, 32'h0);
        fe.redirect = 1'b0;
        step();
        chk("rdself_ifidpc", fe.ifid_pc, 32'h8);
        chk("rdself_instr", fe.ifid_instr, 32'hA5AD);
        chk("rdself_pc2", fe.pc, 32'h9);

        fe.redirect = 1'b1; fe.redirect_pc = 16'h0100;
        step();
        chk("b2b_pc1", fe.pc, 32'h0100);
        fe.redirect_pc = 16'h0200;
        step();
        chk("b2b_pc2", fe.pc, 32'h0200);
        chk("b2b_valid", fe.ifid_valid, 32'h0);
        fe.redirect = 1'b0;
        step();
        chk("b2b_ifidpc", fe.ifid_pc, 32'h0200);
        chk("b2b_instr", fe.ifid_instr, 32'hA7A5);

        fe.redirect = 1'b1; fe.redirect_pc = 16'hFFFF;
        step();
        fe.redirect = 1'b0;
        step();
        chk("wrap_ifidpc", fe.ifid_pc, 32'hFFFF);
        chk("wrap_inc", fe.ifid_pc_inc, 32'h0000);
        chk("wrap_pc", fe.pc, 32'h0000);
        chk("wrap_instr", fe.ifid_instr, 32'h5A5A);
        chk_perf("mid_perf");

        rst = 1'b1;
        step();
        chk("mrst_valid", fe.ifid_valid, 32'h0);
        chk("mrst_instr", fe.ifid_instr, 32'h0);
        chk("mrst_pc", fe.pc, 32'h0);
        chk("mrst_ifidpc", fe.ifid_pc, 32'h0);
        chk_perf("mrst_perf");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step();
        fe.stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        fe.stall = 1'b0;
        fe.redirect = 1'b1; fe.redirect_pc = 16'h0010;
        step(); step();
        fe.redirect = 1'b0;
        chk("t6_imaddr", fe.im_addr, 32'h0010);
`ifdef FETCH_PERF_EN
        chk("t6_fetch",  fe.perf_fetch,  32'd10);
        chk("t6_stall",  fe.perf_stall,  32'd3);
        chk("t6_bubble", fe.perf_bubble, 32'd2);
`else
        chk("t6_fetch",  fe.perf_fetch,  32'd0);
        chk("t6_stall",  fe.perf_stall,  32'd0);
        chk("t6_bubble", fe.perf_bubble, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
